// File: rtl/wisc_pkg.sv
// Shared WISC-SP20 definitions: opcode constants, NOP encoding and the hazard FSM state type.
package wisc_pkg;

    localparam logic [4:0] OP_LD   = 5'b10001;
    localparam logic [4:0] OP_ST   = 5'b10000;
    localparam logic [4:0] OP_STU  = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b00000;

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } hz_state_t;

    // Stores read rt as write data even when decode does not flag it.
    function automatic logic reads_store_data(input logic [4:0] op);
        return (op == OP_ST) || (op == OP_STU);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with increment enable and synchronous reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctl.sv
module hazard_ctl
  import wisc_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction_d,
  input  logic [2:0]        rs_d,
  input  logic [2:0]        rt_d,
  input  logic              valid_rs,
  input  logic              valid_rt,
  input  logic              mem_read_ex,
  input  logic [2:0]        rd_e,
  input  logic              valid_rd_e,
  input  logic              branch_taken_e,
  input  logic              imem_stall,
  input  logic              dmem_stall,
  input  logic              dmem_done,
  input  logic              halt_m,
  output logic              stall_pc,
  output logic              stall_fd,
  output logic              nop_fd,
  output logic              bubble_de,
  output logic              d_Stall,
  output logic              real_stall,
  output logic              flush_fd,
  output logic              halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] lu_count,
  output logic [STAT_W-1:0] mem_wait_count,
  output logic [STAT_W-1:0] flush_count
`endif
);

  hz_state_t state_q, state_d;

  logic dmem_hold;
  logic rt_read;
  logic load_use;
  logic unused_instr_bits;

  assign unused_instr_bits = ^instruction_d[10:0];

  assign dmem_hold = dmem_stall && !dmem_done;
  assign rt_read   = valid_rt || reads_store_data(instruction_d[15:11]);
  assign load_use  = mem_read_ex && valid_rd_e &&
                     ((valid_rs && (rs_d == rd_e)) || (rt_read && (rt_d == rd_e)));

  always_comb begin
    state_d    = state_q;
    stall_pc   = 1'b0;
    stall_fd   = 1'b0;
    nop_fd     = 1'b0;
    bubble_de  = 1'b0;
    d_Stall    = 1'b0;
    real_stall = 1'b0;
    flush_fd   = 1'b0;
    halted     = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem_hold)
          state_d = MEM_WAIT;
        else if (halt_m)
          state_d = HALTED;
        real_stall = dmem_hold;
      end
      MEM_WAIT: begin
        if (dmem_done)
          state_d = halt_m ? HALTED : RUN;
        real_stall = !dmem_done;
      end
      HALTED: begin
        real_stall = 1'b1;
        halted     = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (real_stall) begin
      stall_pc = 1'b1;
      stall_fd = 1'b1;
    end else if (branch_taken_e) begin
      flush_fd = 1'b1;
    end else if (load_use) begin
      d_Stall   = 1'b1;
      bubble_de = 1'b1;
      stall_pc  = 1'b1;
      stall_fd  = 1'b1;
    end else if (imem_stall) begin
      stall_pc = 1'b1;
      nop_fd   = 1'b1;
    end

    if (rst) begin
      stall_pc   = 1'b0;
      stall_fd   = 1'b0;
      nop_fd     = 1'b0;
      bubble_de  = 1'b0;
      d_Stall    = 1'b0;
      real_stall = 1'b0;
      flush_fd   = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] lu_cnt, mem_cnt, flush_cnt;

  sat_counter #(.W(STAT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_Stall),
    .count (lu_cnt)
  );

  sat_counter #(.W(STAT_W)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (real_stall && !halted),
    .count (mem_cnt)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_fd),
    .count (flush_cnt)
  );

  assign lu_count       = rst ? '0 : lu_cnt;
  assign mem_wait_count = rst ? '0 : mem_cnt;
  assign flush_count    = rst ? '0 : flush_cnt;
`endif

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard and stall controller for the five-stage WISC-SP20 core. It produces every stall, bubble and flush the execute stage and the pipeline latches consume, including `d_Stall` and `real_stall`. It sits beside the decode/execute boundary and sees the decode-stage instruction, the execute-stage destination, memory handshakes and branch resolution. A small FSM tracks outstanding data-memory stalls and halt drain.

## Interface
Parameters:
- `STAT_W`, 16: width of the statistics counters (only when `HAZARD_STATS_EN` is defined).

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `instruction_d`  in  16  instruction currently in decode (IF/ID output).
- `rs_d`, `rt_d`  in  3  source registers of `instruction_d`.
- `valid_rs`, `valid_rt`  in  1  the respective source is actually read.
- `mem_read_ex`  in  1  instruction in execute is a load (LD).
- `rd_e`  in  3  destination of the instruction in execute.
- `valid_rd_e`  in  1  `rd_e` is written.
- `branch_taken_e`  in  1  execute resolved a taken branch or jump this cycle.
- `imem_stall`  in  1  instruction memory not ready.
- `dmem_stall`  in  1  data memory busy.
- `dmem_done`  in  1  data memory completes this cycle.
- `halt_m`  in  1  HALT is in the memory stage.
- `stall_pc`  out  1  hold the PC.
- `stall_fd`  out  1  hold the IF/ID latch.
- `nop_fd`  out  1  load a NOP into IF/ID.
- `bubble_de`  out  1  load a NOP into ID/EX.
- `d_Stall`  out  1  load-use stall active.
- `real_stall`  out  1  freeze every pipeline latch and hold execute `data_out`.
- `flush_fd`  out  1  squash the IF/ID contents.
- `halted`  out  1  core halted. Sticky until `rst`.
- `lu_count`, `mem_wait_count`, `flush_count`  out  `STAT_W`  statistics (only when `HAZARD_STATS_EN` is defined).

## Operation
FSM states:
- RUN:
  - to MEM_WAIT if `dmem_stall` and not `dmem_done`.
  - to HALTED if `halt_m` and no memory stall.
- MEM_WAIT:
  - to RUN on `dmem_done`.
  - to HALTED on `dmem_done` with `halt_m`.
- HALTED: terminal. Only `rst` leaves it.

Output rules, evaluated combinationally from the state and inputs. Priority is halt > memory > flush > load-use > imem.
- `real_stall` = (RUN and `dmem_stall` and not `dmem_done`) or (MEM_WAIT and not `dmem_done`) or HALTED.
- `real_stall` forces `stall_pc`=`stall_fd`=1 and `bubble_de`=`nop_fd`=`flush_fd`=`d_Stall`=0.
- `flush_fd` = `branch_taken_e` when `real_stall` is low.
  - Suppresses load-use detection and `d_Stall` that cycle.
  - The decode instruction is being squashed anyway.
- Load-use condition: `mem_read_ex` and `valid_rd_e` and ((`valid_rs` and `rs_d`==`rd_e`) or (`valid_rt` and `rt_d`==`rd_e`)).
  - Store data uses `rt_d`. ST and STU count as reading `rt_d` even when decode reports otherwise, based on `instruction_d[15:11]`.
  - Effect: `d_Stall`=`bubble_de`=`stall_pc`=`stall_fd`=1 for exactly one cycle. Then the load is in memory and forwarding covers the dependence.
- `imem_stall` with no higher-priority event: `stall_pc`=1, `nop_fd`=1.
- `imem_stall` coinciding with load-use: the load-use response applies. `nop_fd`=0 because IF/ID is held.
- `halted`=1 in HALTED.

## Timing
- All outputs 0 and state RUN during and after reset.
- Hazard outputs are same-cycle combinational. There is no added latency.
- Only state and counters are registered.
- A one-cycle `dmem_stall` with `dmem_done` in the same cycle causes no stall and no state change.
- `real_stall` falls in the `dmem_done` cycle, so latches advance that edge.
- `rst` during MEM_WAIT or HALTED returns to RUN on the next edge, with outputs 0.
- Back-to-back load-use pairs each cost exactly one bubble.

## Configuration
- `HAZARD_STATS_EN` defined: three saturating counters, reset to 0.
  - `lu_count` increments on each load-use bubble.
  - `mem_wait_count` increments on each `real_stall` cycle outside HALTED.
  - `flush_count` increments on each `flush_fd`.
  - Each saturates at all-ones and holds.
- Undefined: the counters and their ports are absent. Hazard behaviour is identical.

## Structure
- Shared package `wisc_pkg`:
  - Opcode constants `OP_LD`=5'b10001, `OP_ST`=5'b10000, `OP_STU`=5'b10011, `OP_HALT`=5'b00000.
  - NOP encoding.
  - FSM state enum: RUN, MEM_WAIT, HALTED.
- One sub-module `sat_counter` (width-parameterised, increment enable, synchronous reset), instantiated three times under `HAZARD_STATS_EN`.

## Test plan
- LD R1 in execute (`rd_e`=1, `mem_read_ex`=1), ADD with `rs_d`=1 → exactly one cycle of `d_Stall`=`bubble_de`=`stall_pc`=`stall_fd`=1. Next cycle all are 0. `lu_count`=1.
- STU in decode with `rt_d`=3 and `valid_rt`=0 while LD R3 is in execute → load-use bubble asserted.
- `dmem_stall` high for 4 cycles, `dmem_done` on the 4th → `real_stall` high for 3 cycles, low in the done cycle, state back to RUN. `mem_wait_count`=3.
- `branch_taken_e`=1 with a load-use condition present → `flush_fd`=1, `d_Stall`=0, `bubble_de`=0.
- `halt_m`=1 during MEM_WAIT, then `dmem_done` → `halted`=1 and `real_stall`=1 from the next cycle, persisting. `rst`=1 for one cycle → everything returns to 0.
- `imem_stall`=1 alone → `stall_pc`=`nop_fd`=1 and `stall_fd`=0. With a simultaneous load-use → `nop_fd`=0 and `stall_fd`=1.
